// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
// Width helper returns 0 for n<2 so derived widths stay sane for degenerate params.
package arb_pkg;
  localparam int ARB_MAX_REQ = 16;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

  function automatic int arb_clog2(input int n);
    return (n < 2) ? 0 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
// The doubled vector turns the circular search into a plain lowest-bit encode.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = arb_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;

  always_comb begin
    w_dbl = {req, req};
    w_rot = w_dbl[ptr +: NUM_REQ];
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = ID_W'(i);
    end
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    found = |w_rot;
    idx   = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                           : w_sum[ID_W-1:0];
  end
endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant, hold while requested,
// and an optional MAX_HOLD limit that forces re-arbitration.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = arb_clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout
);
  localparam int                CNT_W     = arb_clog2(MAX_HOLD) + 1;
  localparam bit                TO_EN     = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0]  HOLD_LAST = TO_EN ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_e         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_grant_valid, w_grant_valid_nxt;
  logic [ID_W-1:0]    r_grant_id, w_grant_id_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_hold, w_hold_nxt;

  logic            w_found;
  logic [ID_W-1:0] w_idx;
  logic            w_owner_req, w_to_hit, w_arb;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_timeout     <= 1'b0;
      r_ptr         <= '0;
      r_hold        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_timeout     <= w_timeout_nxt;
      r_ptr         <= w_ptr_nxt;
      r_hold        <= w_hold_nxt;
    end
  end

  // Arbitrate when idle, or when the owner lets go / hits the hold limit.
  always_comb begin
    w_owner_req = req[r_grant_id];
    w_to_hit    = TO_EN && (r_state == BUSY) && w_owner_req && (r_hold == HOLD_LAST);
    w_arb       = (r_state == IDLE) || !w_owner_req || w_to_hit;
    w_state_nxt = r_state;
    if (w_arb) w_state_nxt = w_found ? BUSY : IDLE;
  end

  always_comb begin
    w_grant_nxt       = r_grant;
    w_grant_valid_nxt = r_grant_valid;
    w_grant_id_nxt    = r_grant_id;
    w_ptr_nxt         = r_ptr;
    w_hold_nxt        = TO_EN ? r_hold + 1'b1 : r_hold;
    w_timeout_nxt     = 1'b0;
    if (w_arb) begin
      w_hold_nxt    = '0;
      w_timeout_nxt = w_to_hit;
      if (w_found) begin
        w_grant_nxt       = NUM_REQ'(1) << w_idx;
        w_grant_valid_nxt = 1'b1;
        w_grant_id_nxt    = w_idx;
        w_ptr_nxt         = (w_idx == LAST_ID) ? '0 : w_idx + 1'b1;
      end else begin
        w_grant_nxt       = '0;
        w_grant_valid_nxt = 1'b0;
        w_grant_id_nxt    = '0;
      end
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign timeout     = r_timeout;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: stimulus pushes hand-computed expectations tagged
// with the cycle they become visible; a negedge monitor pops and compares.
module tb_rr_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_a = '0;
  logic [3:0] req_b = '0;
  logic [3:0] grant_a, grant_b;
  logic       gv_a, gv_b, to_a, to_b;
  logic [1:0] gid_a, gid_b;

  typedef struct {
    int       cyc;
    bit       dut;
    logic [3:0] g;
    logic     t;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) u_dut_a (
    .clock(clock), .reset(reset), .req(req_a), .grant(grant_a),
    .grant_valid(gv_a), .grant_id(gid_a), .timeout(to_a)
  );

  rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(0)) u_dut_b (
    .clock(clock), .reset(reset), .req(req_b), .grant(grant_b),
    .grant_valid(gv_b), .grant_id(gid_b), .timeout(to_b)
  );

  function automatic logic [1:0] oh2idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input int c, input logic [3:0] act, input logic [3:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, c, act, req_v);
    end
  endtask

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [3:0] g;
      logic       v, t;
      logic [1:0] id;
      e  = q.pop_front();
      g  = e.dut ? grant_b : grant_a;
      v  = e.dut ? gv_b    : gv_a;
      id = e.dut ? gid_b   : gid_a;
      t  = e.dut ? to_b    : to_a;
      chk(e.dut ? "b_grant" : "a_grant", e.cyc, g, e.g);
      chk(e.dut ? "b_valid" : "a_valid", e.cyc, {3'b0, v}, {3'b0, |e.g});
      chk(e.dut ? "b_id" : "a_id", e.cyc, {2'b0, id}, {2'b0, oh2idx(e.g)});
      chk(e.dut ? "b_timeout" : "a_timeout", e.cyc, {3'b0, t}, {3'b0, e.t});
    end
  end

  task automatic step(input bit rst, input logic [3:0] r, input logic [3:0] eg, input bit et);
    exp_t e;
    @(posedge clock); #1;
    reset = rst;
    req_a = r;
    e.cyc = cyc + 1; e.dut = 1'b0; e.g = eg; e.t = et;
    q.push_back(e);
  endtask

  task automatic stepb(input logic [3:0] r, input logic [3:0] eg, input bit et);
    exp_t e;
    @(posedge clock); #1;
    reset = 1'b0;
    req_b = r;
    e.cyc = cyc + 1; e.dut = 1'b1; e.g = eg; e.t = et;
    q.push_back(e);
  endtask

  initial begin
    // Reset state
    step(1, 4'b0000, 4'b0000, 0);
    step(1, 4'b0000, 4'b0000, 0);

    // 1: reset mid-grant, then index 0 wins first
    repeat (3) step(0, 4'b0010, 4'b0010, 0);
    step(1, 4'b0010, 4'b0000, 0);
    step(0, 4'b1111, 4'b0001, 0);
    step(0, 4'b0000, 4'b0000, 0);

    // 2: round-robin order, back-to-back handoffs
    step(1, 4'b0000, 4'b0000, 0);
    step(0, 4'b1111, 4'b0001, 0);
    step(0, 4'b1111, 4'b0001, 0);
    step(0, 4'b1110, 4'b0010, 0);
    step(0, 4'b1111, 4'b0010, 0);
    step(0, 4'b1101, 4'b0100, 0);
    step(0, 4'b1111, 4'b0100, 0);
    step(0, 4'b1011, 4'b1000, 0);
    step(0, 4'b1111, 4'b1000, 0);
    step(0, 4'b0111, 4'b0001, 0);
    step(0, 4'b0000, 4'b0000, 0);

    // 3: single requester latency and release
    step(0, 4'b0100, 4'b0100, 0);
    step(0, 4'b0100, 4'b0100, 0);
    step(0, 4'b0000, 4'b0000, 0);
    step(0, 4'b0000, 4'b0000, 0);

    // 4: timeout handoff 0 -> 1 -> 0
    step(1, 4'b0000, 4'b0000, 0);
    step(0, 4'b0011, 4'b0001, 0);
    repeat (7) step(0, 4'b0011, 4'b0001, 0);
    step(0, 4'b0011, 4'b0010, 1);
    repeat (7) step(0, 4'b0011, 4'b0010, 0);
    step(0, 4'b0011, 4'b0001, 1);
    step(0, 4'b0000, 4'b0000, 0);

    // 5: sole-owner timeout re-grant (also wraps ptr to 0)
    for (int i = 0; i < 20; i++) step(0, 4'b1000, 4'b1000, (i == 8 || i == 16));
    step(0, 4'b0000, 4'b0000, 0);

    // 5b: timeout disabled on the MAX_HOLD=0 instance
    for (int i = 0; i < 20; i++) stepb(4'b1000, 4'b1000, 0);
    stepb(4'b0000, 4'b0000, 0);

    // 6: requests ignored while busy, then wrap gives 0 priority over 1
    step(0, 4'b1000, 4'b1000, 0);
    step(0, 4'b1010, 4'b1000, 0);
    step(0, 4'b1010, 4'b1000, 0);
    step(0, 4'b0010, 4'b0010, 0);
    step(0, 4'b0000, 4'b0000, 0);
    step(0, 4'b1000, 4'b1000, 0);
    step(0, 4'b1011, 4'b1000, 0);
    step(0, 4'b0011, 4'b0001, 0);
    step(0, 4'b0000, 4'b0000, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    @(negedge clock); #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
Parameterised N-way round-robin arbiter with grant hold and starvation timeout. It shares a single downstream resource (bus, port, memory bank) between NUM_REQ requesters. It generalises the two-input fixed-priority arbiter to fair, lockable, registered grants. It sits between requester blocks and the shared resource's select mux.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
MAX_HOLD, 8, max consecutive cycles one owner may hold the grant; 0 disables the timeout
ID_W, $clog2(NUM_REQ), width of grant_id (derived, not overridden)

Ports:
clock  in  1  single system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset; sampled on rising edge of clock
req  in  NUM_REQ  request vector; bit i high = requester i wants or continues to hold the resource
grant  out  NUM_REQ  one-hot grant, registered; all-zero when idle
grant_valid  out  1  high when any grant bit is set (registered)
grant_id  out  ID_W  binary index of the current owner; 0 when idle
timeout  out  1  one-cycle pulse: grant revoked by the MAX_HOLD limit

Behaviour:
- Reset (synchronous): grant=0, grant_valid=0, grant_id=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides all other activity; it takes effect at the next edge even mid-grant.
- State machine: IDLE, BUSY.
- Round-robin pick: circular search of req starting at index ptr, wrapping from NUM_REQ-1 to 0. The first set bit wins. No set bit means no winner.
- IDLE: if req!=0, register the winner into grant/grant_id and set grant_valid=1, hold_cnt=0, ptr=winner+1 (mod NUM_REQ), and go to BUSY. Latency is exactly 1 cycle from req sampled to grant visible. With req==0, stay in IDLE and keep outputs at 0.
- BUSY, hold: while req[grant_id]=1 and the timeout is not reached, keep the grant unchanged and increment hold_cnt.
- BUSY, release conditions (evaluated on the current edge):
  (a) Owner drop: req[grant_id]=0.
  (b) Timeout: MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 while the owner still requests; timeout=1 for that next cycle only.
- On release: re-arbitrate in the same edge with the pick from ptr.
  - Since ptr=owner+1, the previous owner has lowest priority.
  - A winner present means a back-to-back handoff with no idle bubble; hold_cnt=0 and ptr=new winner+1.
  - No winner means grant=0, grant_valid=0, grant_id=0, return to IDLE.
  - If the timed-out owner is the only requester, it is re-granted and hold_cnt restarts from 0; timeout still pulses.
- Simultaneous requests in IDLE: the ptr-ordered pick decides; after reset, index 0 wins first.
- Requests arriving during BUSY are ignored until release; they are not queued, only req level matters.
- Invariant: grant is always one-hot or zero, and grant_valid == |grant.
- hold_cnt width is $clog2(MAX_HOLD)+1; it never wraps because it is reset on every grant.
- ptr wrap: winner NUM_REQ-1 sets ptr=0.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, BUSY}
  - function clog2-safe width helper
  - constant ARB_MAX_REQ=16
- Sub-module rr_pick: purely combinational. Inputs are req and ptr; outputs are found and idx. It uses a double-width (req,req) rotate-and-priority-encode. It is instantiated once by rr_arbiter, which holds all registers and the FSM.

Test Plan:
(Bench uses NUM_REQ=4, MAX_HOLD=8, clock period 10.)
1. Reset mid-grant: req=4'b0010 for 3 cycles, then reset=1 for 1 edge -> grant=0, grant_valid=0, grant_id=0 at that edge; after release, req=4'b1111 -> grant=4'b0001.
2. Round-robin order: after reset, req=4'b1111 held continuously, with each owner dropping its bit for 1 cycle after 2 held cycles -> grant sequence 0001, 0010, 0100, 1000, 0001 with no idle cycle between owners.
3. Single-requester latency and release: req=4'b0100 at edge k -> grant=4'b0100 and grant_id=2 visible after edge k; req=0 at edge m -> grant=0 after edge m, state IDLE.
4. Timeout: req=4'b0011 held continuously, owner 0 granted -> after 8 held cycles timeout pulses for 1 cycle and grant moves to 4'b0010; after 8 more, grant returns to 4'b0001 with timeout pulse.
5. Sole-owner timeout and disabled timeout: req=4'b1000 held for 20 cycles -> grant stays 4'b1000, with timeout pulsing at cycles 8 and 16. Rerun with MAX_HOLD=0 -> timeout never asserts.
6. Ignore-during-BUSY and wrap: owner 3 granted, req[1] asserts mid-grant, then req[3] drops -> grant=4'b0010 next edge, and ptr wrap gives index 0 priority over 1 if both were set.
